// File: rtl/instr_prefetch_buf_pkg.sv
// Shared definitions for the instruction prefetch buffer: FSM states and
// the sequential fetch stride.
package instr_prefetch_buf_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      DISCARD = 2'd2
   } pf_state_e;

   localparam int unsigned FETCH_INC = 4;

endpackage

// File: rtl/instr_prefetch_buf_fifo.sv
// Small {address, word} FIFO holding prefetched instructions; flush empties
// it in one cycle and overrides any push/pop in that cycle.
module prefetch_fifo #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [ADDR_WIDTH-1:0]    push_addr,
   input  logic [DATA_WIDTH-1:0]    push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [ADDR_WIDTH-1:0]    head_addr,
   output logic [DATA_WIDTH-1:0]    head_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;
   logic                  do_push;
   logic                  do_pop;

   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign occupancy = count;
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Payload storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetcher between the core fetch port and the
// program memory mux, with one memory transaction in flight at most.
module instr_prefetch_buf #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  core_req_i,
   input  logic [ADDR_WIDTH-1:0] core_addr_i,
   output logic                  core_gnt_o,
   output logic                  core_rvalid_o,
   output logic [DATA_WIDTH-1:0] core_rdata_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   import instr_prefetch_buf_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);

   pf_state_e             state;
   logic [ADDR_WIDTH-1:0] fptr;
   logic [ADDR_WIDTH-1:0] infl_addr;
   logic                  outstanding;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [PTR_W:0]        fifo_occ;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

   logic                  hit;
   logic                  pending;
   logic                  miss;
   logic                  mem_grant;
   logic                  rv_accept;
   logic                  fifo_push;
   logic                  out_next;
   logic [PTR_W+1:0]      credit_used;

   assign credit_used = (PTR_W+2)'(fifo_occ) + (PTR_W+2)'(outstanding);
   assign mem_req_o   = (state == STREAM) && !fifo_full && (credit_used < (PTR_W+2)'(DEPTH));
   assign mem_addr_o  = fptr;
   assign mem_grant   = mem_req_o && mem_gnt_i;
   assign rv_accept   = mem_rvalid_i && outstanding;
   assign out_next    = mem_grant || (outstanding && !rv_accept);

   // A request already covered by the stream waits for its word to be
   // pushed instead of restarting the stream; the hit follows the push.
   always_comb begin
      hit     = core_req_i && !fifo_empty && (head_addr == core_addr_i);
      pending = 1'b0;
      if (fifo_empty) begin
         if (state == STREAM)
            pending = outstanding ? (core_addr_i == infl_addr) : (core_addr_i == fptr);
         else if (state == DISCARD)
            pending = (core_addr_i == fptr);
      end
      miss      = core_req_i && !hit && !pending;
      fifo_push = rv_accept && (state == STREAM) && !miss;
   end

   assign core_gnt_o = hit;

   prefetch_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_addr (infl_addr),
      .push_data (mem_rdata_i),
      .pop       (hit),
      .flush     (miss),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .occupancy (fifo_occ),
      .head_addr (head_addr),
      .head_data (head_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         fptr          <= '0;
         infl_addr     <= '0;
         outstanding   <= 1'b0;
         core_rvalid_o <= 1'b0;
         core_rdata_o  <= '0;
      end else begin
         core_rvalid_o <= hit;
         if (hit) core_rdata_o <= head_data;
         outstanding <= out_next;
         if (mem_grant) infl_addr <= fptr;
         // A grant issued in the miss cycle is already stale, so it too
         // must be drained before streaming from the new target.
         if (miss) begin
            fptr  <= core_addr_i;
            state <= out_next ? DISCARD : STREAM;
         end else begin
            if (mem_grant) fptr <= fptr + ADDR_WIDTH'(FETCH_INC);
            if (state == DISCARD && rv_accept) state <= STREAM;
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Directed bench for instr_prefetch_buf against a zero-wait program memory
// that answers one cycle after each grant with word = 0xC0DE0000 | address.
module tb_instr_prefetch_buf;

   logic        clk;
   logic        rst_n;
   logic        core_req_i;
   logic [9:0]  core_addr_i;
   logic        core_gnt_o;
   logic        core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic        mem_req_o;
   logic [9:0]  mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int n_vec;
   int n_err;
   int grants;

   instr_prefetch_buf #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (32),
      .DEPTH      (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .core_req_i    (core_req_i),
      .core_addr_i   (core_addr_i),
      .core_gnt_o    (core_gnt_o),
      .core_rvalid_o (core_rvalid_o),
      .core_rdata_o  (core_rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory is deliberately not reset, so a grant just before reset still answers.
   always @(posedge clk) begin
      mem_rvalid_i <= mem_req_o && mem_gnt_i;
      mem_rdata_i  <= 32'hC0DE_0000 | {22'b0, mem_addr_o};
   end

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      core_req_i = 1'b0;
      nx();
      nx();
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      core_req_i  = 1'b0;
      core_addr_i = '0;
      mem_gnt_i   = 1'b0;
      nx();
      nx();
      chk("rst_core_gnt", 32'(core_gnt_o), 32'd0);
      chk("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
      chk("rst_core_rdata", core_rdata_o, 32'd0);
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
      rst_n = 1'b1;

      // Sequential stream from 0x000
      mem_gnt_i = 1'b1;
      core_req_i = 1'b1; core_addr_i = 10'h000; #1;
      chk("seq_c0_gnt", 32'(core_gnt_o), 32'd0);
      chk("seq_c0_memreq", 32'(mem_req_o), 32'd0);
      nx(); #1;
      chk("seq_c1_memreq", 32'(mem_req_o), 32'd1);
      chk("seq_c1_memaddr", 32'(mem_addr_o), 32'h000);
      chk("seq_c1_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("seq_c2_memaddr", 32'(mem_addr_o), 32'h004);
      chk("seq_c2_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("seq_c3_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      chk("seq_c4_rvalid", 32'(core_rvalid_o), 32'd1);
      chk("seq_c4_rdata", core_rdata_o, 32'hC0DE_0000);
      core_addr_i = 10'h004; #1;
      chk("seq_c4_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      chk("seq_c5_rdata", core_rdata_o, 32'hC0DE_0004);
      core_addr_i = 10'h008; #1;
      chk("seq_c5_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      chk("seq_c6_rdata", core_rdata_o, 32'hC0DE_0008);
      core_addr_i = 10'h00C; #1;
      chk("seq_c6_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      core_req_i = 1'b0;
      chk("seq_c7_rvalid", 32'(core_rvalid_o), 32'd1);
      chk("seq_c7_rdata", core_rdata_o, 32'hC0DE_000C);
      nx();
      chk("seq_c8_rvalid", 32'(core_rvalid_o), 32'd0);
      chk("seq_c8_rdata_hold", core_rdata_o, 32'hC0DE_000C);

      // Branch to 0x100 while the fetch of 0x010 is in flight
      do_reset();
      mem_gnt_i = 1'b1;
      core_req_i = 1'b1; core_addr_i = 10'h010; #1;
      chk("br_c0_gnt", 32'(core_gnt_o), 32'd0);
      nx();
      core_addr_i = 10'h100; #1;
      chk("br_c1_memaddr", 32'(mem_addr_o), 32'h010);
      chk("br_c1_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("br_c2_memreq", 32'(mem_req_o), 32'd0);
      chk("br_c2_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("br_c3_memreq", 32'(mem_req_o), 32'd1);
      chk("br_c3_memaddr", 32'(mem_addr_o), 32'h100);
      chk("br_c3_rvalid", 32'(core_rvalid_o), 32'd0);
      nx(); #1;
      chk("br_c4_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("br_c5_gnt", 32'(core_gnt_o), 32'd1);
      chk("br_c5_rvalid", 32'(core_rvalid_o), 32'd0);
      nx();
      core_req_i = 1'b0;
      chk("br_c6_rvalid", 32'(core_rvalid_o), 32'd1);
      chk("br_c6_rdata", core_rdata_o, 32'hC0DE_0100);

      // FIFO fills with no core requests
      do_reset();
      mem_gnt_i = 1'b1;
      core_req_i = 1'b1; core_addr_i = 10'h200; #1;
      chk("full_c0_gnt", 32'(core_gnt_o), 32'd0);
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         nx();
         core_req_i = 1'b0; #1;
         if (mem_req_o && mem_gnt_i) grants++;
      end
      chk("full_grant_count", 32'(grants), 32'd4);
      chk("full_memreq_low", 32'(mem_req_o), 32'd0);
      nx();
      core_req_i = 1'b1; core_addr_i = 10'h200; #1;
      chk("full_hit_200", 32'(core_gnt_o), 32'd1);
      nx();
      chk("full_rdata_200", core_rdata_o, 32'hC0DE_0200);
      core_addr_i = 10'h204; #1;
      chk("full_hit_204", 32'(core_gnt_o), 32'd1);
      nx();
      core_addr_i = 10'h208; #1;
      chk("full_hit_208", 32'(core_gnt_o), 32'd1);
      nx();
      core_addr_i = 10'h20C; #1;
      chk("full_hit_20c", 32'(core_gnt_o), 32'd1);
      nx();
      core_req_i = 1'b0;
      chk("full_rdata_20c", core_rdata_o, 32'hC0DE_020C);

      // Address wrap from 0x3F8
      do_reset();
      mem_gnt_i = 1'b1;
      core_req_i = 1'b1; core_addr_i = 10'h3F8; #1;
      chk("wrap_c0_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("wrap_c1_memaddr", 32'(mem_addr_o), 32'h3F8);
      nx(); #1;
      chk("wrap_c2_memaddr", 32'(mem_addr_o), 32'h3FC);
      nx(); #1;
      chk("wrap_c3_memaddr", 32'(mem_addr_o), 32'h000);
      chk("wrap_c3_memreq", 32'(mem_req_o), 32'd1);
      chk("wrap_c3_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      core_addr_i = 10'h3FC; #1;
      chk("wrap_c4_gnt", 32'(core_gnt_o), 32'd1);
      chk("wrap_c4_rdata", core_rdata_o, 32'hC0DE_03F8);
      nx();
      core_addr_i = 10'h000; #1;
      chk("wrap_c5_gnt", 32'(core_gnt_o), 32'd1);
      chk("wrap_c5_rdata", core_rdata_o, 32'hC0DE_03FC);
      nx();
      core_req_i = 1'b0;
      chk("wrap_c6_rdata", core_rdata_o, 32'hC0DE_0000);

      // Memory stalled for five cycles
      do_reset();
      mem_gnt_i = 1'b0;
      core_req_i = 1'b1; core_addr_i = 10'h040; #1;
      chk("stall_c0_gnt", 32'(core_gnt_o), 32'd0);
      for (int i = 0; i < 5; i++) begin
         nx(); #1;
         chk("stall_memreq", 32'(mem_req_o), 32'd1);
         chk("stall_memaddr", 32'(mem_addr_o), 32'h040);
         chk("stall_gnt", 32'(core_gnt_o), 32'd0);
      end
      nx();
      mem_gnt_i = 1'b1; #1;
      chk("stall_c6_memreq", 32'(mem_req_o), 32'd1);
      nx(); #1;
      chk("stall_c7_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("stall_c8_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      core_req_i = 1'b0; #1;
      chk("stall_c9_rvalid", 32'(core_rvalid_o), 32'd1);
      chk("stall_c9_rdata", core_rdata_o, 32'hC0DE_0040);
      chk("stall_c9_memreq", 32'(mem_req_o), 32'd1);
      chk("stall_c9_memaddr", 32'(mem_addr_o), 32'h04C);

      // Reset mid-stream with the 0x04C response still to arrive
      nx();
      rst_n = 1'b0; #1;
      chk("arst_core_gnt", 32'(core_gnt_o), 32'd0);
      chk("arst_core_rvalid", 32'(core_rvalid_o), 32'd0);
      chk("arst_core_rdata", core_rdata_o, 32'd0);
      chk("arst_mem_req", 32'(mem_req_o), 32'd0);
      chk("arst_mem_addr", 32'(mem_addr_o), 32'd0);
      #1 rst_n = 1'b1;
      nx();
      chk("stale_rvalid", 32'(core_rvalid_o), 32'd0);
      core_req_i = 1'b1; core_addr_i = 10'h04C; #1;
      chk("stale_c0_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("stale_c1_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("stale_c2_gnt", 32'(core_gnt_o), 32'd0);
      nx(); #1;
      chk("stale_c3_gnt", 32'(core_gnt_o), 32'd1);
      nx();
      core_req_i = 1'b0;
      chk("stale_c4_rvalid", 32'(core_rvalid_o), 32'd1);
      chk("stale_c4_rdata", core_rdata_o, 32'hC0DE_004C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_buf.md
INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, the program byte-address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, the instruction word width.
REQ-003 The module SHALL have parameter DEPTH, default 4, the FIFO entry count; it SHALL be a power of two and at least 2.
REQ-004 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-006 Port core_req_i SHALL be an input, 1 bit, the core fetch request.
REQ-007 Port core_addr_i SHALL be an input, ADDR_WIDTH bits, the core fetch byte address (word aligned).
REQ-008 Port core_gnt_o SHALL be an output, 1 bit, the fetch grant.
REQ-009 Port core_rvalid_o SHALL be an output, 1 bit, the fetch data valid.
REQ-010 Port core_rdata_o SHALL be an output, DATA_WIDTH bits, the instruction word.
REQ-011 Port mem_req_o SHALL be an output, 1 bit, the request to the program memory mux.
REQ-012 Port mem_addr_o SHALL be an output, ADDR_WIDTH bits, the memory fetch address.
REQ-013 Port mem_gnt_i SHALL be an input, 1 bit, the memory grant.
REQ-014 Port mem_rvalid_i SHALL be an input, 1 bit, the memory data valid (one cycle after a grant).
REQ-015 Port mem_rdata_i SHALL be an input, DATA_WIDTH bits, the memory read data.

Function
REQ-016 The module SHALL keep a DEPTH-entry FIFO of {address, word}, a fetch pointer fptr, and an outstanding flag (at most one memory transaction in flight).
REQ-017 FSM states SHALL be IDLE (no stream), STREAM (prefetching sequentially) and DISCARD (draining a stale in-flight response).
REQ-018 In STREAM, mem_req_o SHALL be asserted with mem_addr_o=fptr whenever FIFO occupancy plus outstanding is less than DEPTH; on mem_gnt_i, fptr SHALL advance by 4 modulo 2^ADDR_WIDTH.
REQ-019 On mem_rvalid_i in STREAM, mem_rdata_i SHALL be pushed with its address; a push SHALL never be dropped, since credit was reserved at grant.
REQ-020 Hit: core_req_i with FIFO non-empty and head address equal to core_addr_i SHALL assert core_gnt_o combinationally in that cycle, pop the head, and drive core_rvalid_o=1 with the head word in the next cycle.
REQ-021 Miss: core_req_i with no hit SHALL hold core_gnt_o=0, flush the FIFO and set fptr=core_addr_i; the state SHALL become DISCARD if a response is outstanding, otherwise STREAM.
REQ-022 DISCARD SHALL drop the pending mem_rvalid_i word, keep mem_req_o=0, and then enter STREAM.
REQ-023 A push and a pop in the same cycle SHALL leave occupancy unchanged; if the FIFO is empty, a response whose address matches a pending core_addr_i SHALL NOT bypass, and the hit SHALL occur the cycle after the push.
REQ-024 core_rvalid_o SHALL be 1 for exactly one cycle per grant, and core_rdata_o SHALL hold its last value otherwise.
REQ-025 Best-case latency from core_req_i on a hit SHALL be gnt in cycle 0 and rvalid in cycle 1; a cold miss SHALL take 3 cycles to grant (req, mem gnt, mem rvalid/push, hit).

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE, the FIFO empty, fptr=0, outstanding=0, and core_gnt_o, core_rvalid_o, mem_req_o, core_rdata_o and mem_addr_o all 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the in-flight response; after reset, the first mem_rvalid_i SHALL be ignored unless a grant was issued after reset.

Structure
REQ-028 The shared package/defines file SHALL hold the FSM state encodings and the fetch-increment constant (4).
REQ-029 The FIFO SHALL be a sub-module named prefetch_fifo (push, pop, flush, full, empty, occupancy).

Verification
REQ-030 Sequential stream: after reset, requesting 0x000, 0x004, 0x008 and 0x00C with zero-wait memory SHALL give the first gnt at cycle 3, then one gnt/rvalid per cycle, with data equal to memory contents.
REQ-031 Branch with outstanding fetch: a request for 0x100 while the fetch of 0x010 is in flight SHALL discard the 0x010 data, issue mem_addr_o=0x100 after the drain, and return the word at 0x100.
REQ-032 Full FIFO: with core_req_i=0 for 10 cycles, exactly DEPTH=4 memory grants SHALL occur and mem_req_o SHALL then drop.
REQ-033 Wrap: streaming from 0x3F8 SHALL fetch 0x3F8, 0x3FC and 0x000 in order.
REQ-034 Stalled memory: holding mem_gnt_i=0 for 5 cycles SHALL keep mem_req_o and mem_addr_o stable, with core_gnt_o=0 while the FIFO is empty.
REQ-035 Reset asserted mid-stream SHALL set all outputs to 0 immediately (asynchronously), and a stale mem_rvalid_i after release SHALL produce no core_rvalid_o.
